// File: rtl/adc_frame_receiver.sv
// Serial ADC frame receiver: owns the frame position counter, captures N_CH MSB-first
// words from iADC_DOUT at fixed tick positions and publishes them atomically at frame end.
module adc_frame_receiver #(
    parameter int DATA_W       = 12,
    parameter int N_CH         = 2,
    parameter int FRAME_LEN    = 80,
    parameter int FIRST_SAMPLE = 19,
    parameter int CH_STRIDE    = 32
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iTICK,
    input  logic                         iSTART,
    input  logic                         iABORT,
    input  logic                         iCLR_OVR,
    input  logic                         iADC_DOUT,
    output logic [N_CH*DATA_W-1:0]       oDATA,
    output logic                         oVALID,
    output logic                         oBUSY,
    output logic [$clog2(FRAME_LEN)-1:0] oCOUNT,
    output logic                         oOVERRUN
);

    localparam int CNT_W  = $clog2(FRAME_LEN);
    localparam int WORD_W = N_CH * DATA_W;

    // Sample slots must not overlap and the last slot must precede the final tick.
    generate
        if ((CH_STRIDE < 2 * DATA_W) ||
            (FIRST_SAMPLE + (N_CH - 1) * CH_STRIDE + 2 * (DATA_W - 1) >= FRAME_LEN - 1)) begin : g_bad_cfg
            $error("adc_frame_receiver: illegal DATA_W/N_CH/FRAME_LEN/FIRST_SAMPLE/CH_STRIDE combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [WORD_W-1:0]  shadow_reg, shadow_next;
    logic [WORD_W-1:0]  data_reg, data_next;
    logic               valid_reg, valid_next;
    logic               overrun_reg, overrun_next;
    logic               busy;

    logic [WORD_W-1:0]  hit_vec;
    logic [WORD_W-1:0]  capture_vec;

    // One comparator per shadow bit: bit k of channel c lives at a fixed frame position.
    genvar gi, gj;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            for (gj = 0; gj < DATA_W; gj++) begin : g_bit
                localparam int BIT_IDX = gi * DATA_W + DATA_W - 1 - gj;
                localparam int POS     = FIRST_SAMPLE + gi * CH_STRIDE + 2 * gj;
                assign hit_vec[BIT_IDX]     = (count_reg == CNT_W'(POS));
                assign capture_vec[BIT_IDX] = hit_vec[BIT_IDX] ? iADC_DOUT : shadow_reg[BIT_IDX];
            end
        end
    endgenerate

    assign busy = (state_reg != ST_IDLE);

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        shadow_next  = shadow_reg;
        data_next    = data_reg;
        valid_next   = 1'b0;
        overrun_next = overrun_reg;

        // A set in the same cycle as a clear must survive.
        if (iSTART && busy) begin
            overrun_next = 1'b1;
        end else if (iCLR_OVR) begin
            overrun_next = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                count_next = '0;
                if (!iABORT && iSTART) begin
                    state_next  = ST_RUN;
                    shadow_next = '0;
                end
            end
            ST_RUN: begin
                if (iABORT) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (iTICK) begin
                    shadow_next = capture_vec;
                    if (count_reg == CNT_W'(FRAME_LEN - 1)) begin
                        count_next = '0;
                        state_next = ST_DONE;
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                count_next = '0;
                if (!iABORT) begin
                    data_next  = shadow_reg;
                    valid_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            shadow_reg  <= '0;
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            shadow_reg  <= shadow_next;
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign oDATA    = data_reg;
    assign oVALID   = valid_reg;
    assign oBUSY    = busy;
    assign oCOUNT   = count_reg;
    assign oOVERRUN = overrun_reg;

endmodule

// File: tb/tb_adc_frame_receiver.sv
// Self-checking bench for adc_frame_receiver: frame-level model plus directed frames.
module tb_adc_frame_receiver;

    localparam int DW = 12;
    localparam int NC = 2;
    localparam int FL = 80;
    localparam int FS = 19;
    localparam int CS = 32;
    localparam int LIM = 2000;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iTICK = 1'b0;
    logic          iSTART = 1'b0;
    logic          iABORT = 1'b0;
    logic          iCLR_OVR = 1'b0;
    logic          iADC_DOUT = 1'b0;
    logic [NC*DW-1:0] oDATA;
    logic          oVALID;
    logic          oBUSY;
    logic [6:0]    oCOUNT;
    logic          oOVERRUN;

    // Second configuration: four 8-bit channels.
    logic          start8 = 1'b0;
    logic          dout8 = 1'b0;
    logic          tick8 = 1'b1;
    logic          abort8 = 1'b0;
    logic          clr8 = 1'b0;
    logic [31:0]   data8;
    logic          valid8;
    logic          busy8;
    logic [6:0]    count8;
    logic          ovr8;

    int checks = 0;
    int errors = 0;

    always #10 iCLK = ~iCLK;

    adc_frame_receiver dut (
        .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iSTART(iSTART), .iABORT(iABORT),
        .iCLR_OVR(iCLR_OVR), .iADC_DOUT(iADC_DOUT), .oDATA(oDATA), .oVALID(oVALID),
        .oBUSY(oBUSY), .oCOUNT(oCOUNT), .oOVERRUN(oOVERRUN)
    );

    adc_frame_receiver #(
        .DATA_W(8), .N_CH(4), .FRAME_LEN(80), .FIRST_SAMPLE(3), .CH_STRIDE(18)
    ) dut8 (
        .iCLK(iCLK), .iRST(iRST), .iTICK(tick8), .iSTART(start8), .iABORT(abort8),
        .iCLR_OVR(clr8), .iADC_DOUT(dout8), .oDATA(data8), .oVALID(valid8),
        .oBUSY(busy8), .oCOUNT(count8), .oOVERRUN(ovr8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: records the ADC bit seen at every tick position of a frame
    // and assembles the words from those positions when the frame is published.
    logic           samp [0:FL-1];
    int             m_pos = 0;
    bit             m_run = 0;
    bit             m_pend = 0;
    logic [NC*DW-1:0] m_data = '0;
    bit             m_valid = 0;
    bit             m_ovr = 0;

    function automatic logic [NC*DW-1:0] assemble();
        logic [NC*DW-1:0] w;
        w = '0;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < DW; k++)
                w[c*DW + DW-1-k] = samp[FS + c*CS + 2*k];
        return w;
    endfunction

    always @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            m_run = 0; m_pend = 0; m_pos = 0; m_data = '0; m_valid = 0; m_ovr = 0;
        end else begin
            bit was_busy;
            was_busy = m_run || m_pend;
            m_valid = 0;
            if (iSTART && was_busy) m_ovr = 1;
            else if (iCLR_OVR) m_ovr = 0;
            if (m_pend) begin
                m_pend = 0;
                if (!iABORT) begin
                    m_data = assemble();
                    m_valid = 1;
                end
            end else if (m_run) begin
                if (iABORT) begin
                    m_run = 0; m_pos = 0;
                end else if (iTICK) begin
                    samp[m_pos] = iADC_DOUT;
                    if (m_pos == FL-1) begin
                        m_pos = 0; m_run = 0; m_pend = 1;
                    end else begin
                        m_pos++;
                    end
                end
            end else if (iSTART && !iABORT) begin
                m_run = 1;
                for (int i = 0; i < FL; i++) samp[i] = 1'b0;
            end
        end
    end

    always @(negedge iCLK) begin
        chk("data",    64'(oDATA),    64'(m_data));
        chk("valid",   64'(oVALID),   64'(m_valid));
        chk("busy",    64'(oBUSY),    64'(m_run || m_pend));
        chk("count",   64'(oCOUNT),   64'(m_pos));
        chk("overrun", 64'(oOVERRUN), 64'(m_ovr));
    end

    // Stimulus
    logic [DW-1:0] word_w [0:NC-1];
    int tick_period = 1;
    int phase = 0;

    function automatic logic want_bit(input int p);
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < DW; k++)
                if (p == FS + c*CS + 2*k) return word_w[c][DW-1-k];
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic drive(input bit st, input bit ab, input bit cl);
        iSTART = st;
        iABORT = ab;
        iCLR_OVR = cl;
        iTICK = ((phase % tick_period) == 0);
        phase++;
        if (iTICK) iADC_DOUT = m_run ? want_bit(m_pos) : logic'($urandom_range(0, 1));
        else       iADC_DOUT = ~iADC_DOUT;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iCLK);
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Runs one frame; returns negedges from the iSTART drive until oVALID is seen.
    task automatic frame(input logic [DW-1:0] wx, input logic [DW-1:0] wy, input int period,
                         input int ovr_pos, input bit ovr_pub, input int abort_pos,
                         input bit clr_with_ovr, output int ncyc, output int maxc);
        bit st, ab, fired_o, fired_a;
        word_w[0] = wx;
        word_w[1] = wy;
        tick_period = period;
        phase = 0;
        fired_o = 0;
        fired_a = 0;
        maxc = 0;
        ncyc = 0;
        @(negedge iCLK);
        drive(1'b1, 1'b0, 1'b0);
        while (1) begin
            @(negedge iCLK);
            ncyc++;
            if (int'(oCOUNT) > maxc) maxc = int'(oCOUNT);
            if (oVALID || fired_a || ncyc >= LIM) begin
                drive(1'b0, 1'b0, 1'b0);
                break;
            end
            st = 0;
            ab = 0;
            if (!fired_o && m_run && m_pos == ovr_pos) begin st = 1; fired_o = 1; end
            if (ovr_pub && m_pend) st = 1;
            if (!fired_a && m_run && m_pos == abort_pos) begin ab = 1; fired_a = 1; end
            drive(st, ab, clr_with_ovr && st);
        end
        if (abort_pos < 0) chk("frame_timeout", 64'(ncyc < LIM), 64'(1));
        $display("frame: x=%h y=%h period=%0d cycles=%0d oDATA=%h oOVERRUN=%0d",
                 wx, wy, period, ncyc, oDATA, oOVERRUN);
    endtask

    function automatic logic bit8(input int p);
        logic [7:0] w8 [0:3];
        w8[0] = 8'h81; w8[1] = 8'h7E; w8[2] = 8'hFF; w8[3] = 8'h00;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 8; k++)
                if (p == 3 + c*18 + 2*k) return w8[c][7-k];
        return 1'b1;
    endfunction

    initial begin
        int n, mx, seen, guard;

        idle(3);
        chk("reset_data",  64'(oDATA),    64'h0);
        chk("reset_busy",  64'(oBUSY),    64'h0);
        chk("reset_count", 64'(oCOUNT),   64'h0);
        @(negedge iCLK);
        iRST = 1'b0;
        idle(2);

        // Basic frame, tick every cycle
        frame(12'hA5C, 12'h3F1, 1, -1, 0, -1, 0, n, mx);
        chk("f1_latency", 64'(n), 64'd82);
        chk("f1_data", 64'(oDATA), 64'h3F1A5C);
        chk("f1_maxcount", 64'(mx), 64'd79);
        idle(1);
        chk("f1_valid_one_cycle", 64'(oVALID), 64'h0);
        idle(2);

        frame(12'h123, 12'h456, 1, -1, 0, -1, 0, n, mx);
        chk("f2_data", 64'(oDATA), 64'h456123);
        idle(2);

        // Overrun at count 40 and at the publish cycle
        frame(12'hA5C, 12'h3F1, 1, 40, 1, -1, 0, n, mx);
        chk("ovr_data", 64'(oDATA), 64'h3F1A5C);
        chk("ovr_flag", 64'(oOVERRUN), 64'h1);
        @(negedge iCLK); drive(1'b0, 1'b0, 1'b1);
        @(negedge iCLK); drive(1'b0, 1'b0, 1'b0);
        chk("ovr_cleared", 64'(oOVERRUN), 64'h0);
        idle(2);

        // Set and clear together: set wins
        frame(12'h123, 12'h456, 1, 10, 0, -1, 1, n, mx);
        chk("ovr_set_wins", 64'(oOVERRUN), 64'h1);
        chk("f4_data", 64'(oDATA), 64'h456123);
        idle(2);

        // Abort at count 60
        frame(12'hA5C, 12'h3F1, 1, -1, 0, 60, 0, n, mx);
        chk("abort_busy", 64'(oBUSY), 64'h0);
        chk("abort_data", 64'(oDATA), 64'h456123);
        seen = 0;
        repeat (90) begin
            @(negedge iCLK); drive(1'b0, 1'b0, 1'b0);
            if (oVALID) seen = 1;
        end
        chk("abort_no_valid", 64'(seen), 64'h0);

        // Restart with sparse ticks and a toggling data line between ticks
        frame(12'hA5C, 12'h3F1, 4, -1, 0, -1, 0, n, mx);
        chk("sparse_data", 64'(oDATA), 64'h3F1A5C);
        chk("sparse_latency", 64'(n), 64'd322);
        idle(2);

        // Reset mid-frame at count 30
        tick_period = 1;
        phase = 0;
        @(negedge iCLK); drive(1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_pos != 30 && guard < LIM) begin
            @(negedge iCLK); drive(1'b0, 1'b0, 1'b0);
            guard++;
        end
        chk("rst_reach_30", 64'(guard < LIM), 64'h1);
        #2 iRST = 1'b1;
        #1;
        chk("rst_async_data",  64'(oDATA),    64'h0);
        chk("rst_async_busy",  64'(oBUSY),    64'h0);
        chk("rst_async_count", 64'(oCOUNT),   64'h0);
        chk("rst_async_ovr",   64'(oOVERRUN), 64'h0);
        chk("rst_async_valid", 64'(oVALID),   64'h0);
        $display("reset asserted mid-frame at count 30");
        idle(2);
        iRST = 1'b0;
        seen = 0;
        repeat (100) begin
            @(negedge iCLK); drive(1'b0, 1'b0, 1'b0);
            if (oVALID) seen = 1;
        end
        chk("rst_no_stray_valid", 64'(seen), 64'h0);

        // Four-channel 8-bit configuration
        @(negedge iCLK); start8 = 1'b1;
        @(negedge iCLK); start8 = 1'b0;
        for (int p = 0; p < 80; p++) begin
            dout8 = bit8(p);
            @(negedge iCLK);
        end
        seen = 0;
        for (int w = 0; w < 5 && !seen; w++) begin
            if (valid8) seen = 1;
            else @(negedge iCLK);
        end
        chk("cfg8_valid", 64'(seen), 64'h1);
        chk("cfg8_data", 64'(data8), 64'h00FF7E81);
        chk("cfg8_busy", 64'(busy8), 64'h0);
        chk("cfg8_count", 64'(count8), 64'h0);
        chk("cfg8_ovr", 64'(ovr8), 64'h0);
        $display("frame cfg8: oDATA=%h", data8);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
